// File: rtl/axi_fsrc_tx_sequencer.sv
// Control sequencer for the FSRC TX rate converter: turns regmap commands and an
// optional external trigger into registered datapath strobes and accumulator values.
module axi_fsrc_tx_sequencer #(
  parameter int ACCUM_WIDTH = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cfg_enable,
  input  logic                   cfg_ext_trig_en,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  input  logic                   cfg_change_rate,
  input  logic [CNT_WIDTH-1:0]   cfg_start_delay,
  input  logic [CNT_WIDTH-1:0]   cfg_stop_drain,
  input  logic [ACCUM_WIDTH-1:0] cfg_accum_set_val,
  input  logic [ACCUM_WIDTH-1:0] cfg_accum_add_val,
  input  logic                   ext_trig,
  output logic                   fsrc_en,
  output logic                   fsrc_data_start,
  output logic                   fsrc_stop,
  output logic                   accum_set,
  output logic [ACCUM_WIDTH-1:0] accum_set_val,
  output logic [ACCUM_WIDTH-1:0] accum_add_val,
  output logic [2:0]             stat_state,
  output logic                   stat_running
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    LOAD  = 3'd2,
    DELAY = 3'd3,
    RUN   = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ext_trig_d;
  logic                 trig_rise;

  assign trig_rise  = ext_trig & ~ext_trig_d;
  assign stat_state = state_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!cfg_enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (cfg_start && !cfg_stop) state_d = ARMED;
        ARMED: begin
          if (cfg_stop)                             state_d = IDLE;
          else if (!cfg_ext_trig_en || trig_rise)   state_d = LOAD;
        end
        LOAD: begin
          cnt_d   = cfg_start_delay;
          state_d = cfg_stop ? IDLE : DELAY;
        end
        DELAY: begin
          if (cfg_stop)          state_d = IDLE;
          else if (cnt_q == '0)  state_d = RUN;
          else                   cnt_d   = cnt_q - 1'b1;
        end
        RUN: begin
          if (cfg_stop) begin
            state_d = DRAIN;
            cnt_d   = cfg_stop_drain;
          end
        end
        DRAIN: begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so each one lines up with stat_state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      ext_trig_d      <= 1'b0;
      fsrc_en         <= 1'b0;
      fsrc_data_start <= 1'b0;
      fsrc_stop       <= 1'b1;
      accum_set       <= 1'b0;
      accum_set_val   <= '0;
      accum_add_val   <= '0;
      stat_running    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ext_trig_d      <= ext_trig;
      fsrc_en         <= state_d inside {LOAD, DELAY, RUN, DRAIN};
      fsrc_stop       <= !(state_d inside {RUN, DRAIN});
      fsrc_data_start <= (state_d == RUN) && (state_q != RUN);
      accum_set       <= (state_d == LOAD);
      stat_running    <= (state_d == RUN);
      if (state_d == LOAD) begin
        accum_set_val <= cfg_accum_set_val;
        accum_add_val <= cfg_accum_add_val;
      end else if (cfg_enable && cfg_change_rate && (state_q inside {RUN, DRAIN})) begin
        accum_add_val <= cfg_accum_add_val;
      end
    end
  end

endmodule

// File: tb/tb_axi_fsrc_tx_sequencer.sv
// Directed bench for axi_fsrc_tx_sequencer: inputs change 1 ns after each rising edge,
// outputs are checked in the same window against hand-computed values.
module tb_axi_fsrc_tx_sequencer;

  localparam int AW = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cfg_enable, cfg_ext_trig_en, cfg_start, cfg_stop, cfg_change_rate;
  logic [CW-1:0] cfg_start_delay, cfg_stop_drain;
  logic [AW-1:0] cfg_accum_set_val, cfg_accum_add_val;
  logic          ext_trig;
  logic          fsrc_en, fsrc_data_start, fsrc_stop, accum_set, stat_running;
  logic [AW-1:0] accum_set_val, accum_add_val;
  logic [2:0]    stat_state;

  int n_checks = 0;
  int n_fails  = 0;

  axi_fsrc_tx_sequencer #(.ACCUM_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .cfg_enable        (cfg_enable),
    .cfg_ext_trig_en   (cfg_ext_trig_en),
    .cfg_start         (cfg_start),
    .cfg_stop          (cfg_stop),
    .cfg_change_rate   (cfg_change_rate),
    .cfg_start_delay   (cfg_start_delay),
    .cfg_stop_drain    (cfg_stop_drain),
    .cfg_accum_set_val (cfg_accum_set_val),
    .cfg_accum_add_val (cfg_accum_add_val),
    .ext_trig          (ext_trig),
    .fsrc_en           (fsrc_en),
    .fsrc_data_start   (fsrc_data_start),
    .fsrc_stop         (fsrc_stop),
    .accum_set         (accum_set),
    .accum_set_val     (accum_set_val),
    .accum_add_val     (accum_add_val),
    .stat_state        (stat_state),
    .stat_running      (stat_running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse occupies cycle t; returns in cycle t+1.
  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  initial begin
    logic seen;
    resetn = 1'b0;
    cfg_enable = 1'b0; cfg_ext_trig_en = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0;
    cfg_change_rate = 1'b0; cfg_start_delay = '0; cfg_stop_drain = '0;
    cfg_accum_set_val = '0; cfg_accum_add_val = '0; ext_trig = 1'b0;

    // Reset held while stimulus toggles
    for (int i = 0; i < 4; i++) begin
      cfg_enable = 1'b1; cfg_start = i[0]; ext_trig = ~i[0];
      cfg_accum_set_val = 64'hAA; cfg_accum_add_val = 64'hBB; cfg_change_rate = 1'b1;
      tick();
    end
    check("rst_state",   stat_state, 3'd0);
    check("rst_stop",    fsrc_stop, 1'b1);
    check("rst_en",      fsrc_en, 1'b0);
    check("rst_dstart",  fsrc_data_start, 1'b0);
    check("rst_aset",    accum_set, 1'b0);
    check("rst_setval",  accum_set_val, 64'h0);
    check("rst_addval",  accum_add_val, 64'h0);
    check("rst_running", stat_running, 1'b0);
    cfg_start = 1'b0; ext_trig = 1'b0; cfg_change_rate = 1'b0;
    resetn = 1'b1;
    tick();
    check("idle_state", stat_state, 3'd0);

    // Basic start, trigger disabled, delay 3
    cfg_start_delay = 16'd3; cfg_accum_set_val = 64'h10; cfg_accum_add_val = 64'h5;
    pulse_start();                                   // t+1
    check("b_armed", stat_state, 3'd1);
    check("b_armed_en", fsrc_en, 1'b0);
    tick();                                          // t+2
    check("b_load", stat_state, 3'd2);
    check("b_aset", accum_set, 1'b1);
    check("b_setval", accum_set_val, 64'h10);
    check("b_addval", accum_add_val, 64'h5);
    check("b_load_en", fsrc_en, 1'b1);
    tick();                                          // t+3
    check("b_delay", stat_state, 3'd3);
    check("b_aset_off", accum_set, 1'b0);
    check("b_delay_stop", fsrc_stop, 1'b1);
    tick(); tick(); tick();                          // t+6
    check("b_delay_last", stat_state, 3'd3);
    check("b_no_dstart", fsrc_data_start, 1'b0);
    tick();                                          // t+7
    check("b_run", stat_state, 3'd4);
    check("b_dstart", fsrc_data_start, 1'b1);
    check("b_running", stat_running, 1'b1);
    check("b_run_stop", fsrc_stop, 1'b0);
    tick();
    check("b_dstart_once", fsrc_data_start, 1'b0);

    // Rate change in RUN
    cfg_accum_add_val = 64'h9; cfg_change_rate = 1'b1;
    tick();
    cfg_change_rate = 1'b0;
    check("rc_addval", accum_add_val, 64'h9);
    check("rc_no_aset", accum_set, 1'b0);
    check("rc_setval", accum_set_val, 64'h10);
    check("rc_state", stat_state, 3'd4);

    // Stop with drain 4 -> 5 DRAIN cycles
    cfg_stop_drain = 16'd4; cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain_state%0d", i), stat_state, 3'd5);
      check($sformatf("drain_stop%0d", i), fsrc_stop, 1'b0);
      tick();
    end
    check("drain_done", stat_state, 3'd0);
    check("drain_fstop", fsrc_stop, 1'b1);
    check("drain_en", fsrc_en, 1'b0);
    check("drain_running", stat_running, 1'b0);

    // Rate change ignored in IDLE
    cfg_accum_add_val = 64'h77; cfg_change_rate = 1'b1;
    tick();
    cfg_change_rate = 1'b0;
    check("rc_idle_ignored", accum_add_val, 64'h9);

    // External trigger, delay 0
    cfg_ext_trig_en = 1'b1; cfg_start_delay = 16'd0; cfg_accum_add_val = 64'h5;
    pulse_start();
    repeat (20) tick();
    check("trig_wait", stat_state, 3'd1);
    ext_trig = 1'b1;                                 // cycle k
    tick();                                          // k+1
    check("trig_load", stat_state, 3'd2);
    check("trig_aset", accum_set, 1'b1);
    ext_trig = 1'b0;
    tick();
    check("trig_delay", stat_state, 3'd3);
    tick();
    check("trig_run", stat_state, 3'd4);
    check("trig_dstart", fsrc_data_start, 1'b1);

    // Enable dropped in RUN
    cfg_enable = 1'b0;
    tick();
    check("en_drop_state", stat_state, 3'd0);
    check("en_drop_fen", fsrc_en, 1'b0);
    check("en_drop_fstop", fsrc_stop, 1'b1);
    cfg_enable = 1'b1; cfg_ext_trig_en = 1'b0;

    // Abort during DELAY
    cfg_start_delay = 16'd5;
    pulse_start();                                   // ARMED
    tick();                                          // LOAD
    tick();                                          // DELAY
    check("ab_delay", stat_state, 3'd3);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    check("ab_idle", stat_state, 3'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= fsrc_data_start | (stat_state != 3'd0);
      tick();
    end
    check("ab_no_run", seen, 1'b0);

    // Start and stop together in IDLE
    cfg_start = 1'b1; cfg_stop = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_stop = 1'b0;
    check("ss_idle0", stat_state, 3'd0);
    tick();
    check("ss_idle1", stat_state, 3'd0);

    // Reset mid-RUN, then restart
    cfg_start_delay = 16'd0;
    pulse_start();
    tick(); tick(); tick();
    check("mr_run", stat_state, 3'd4);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("mr_state", stat_state, 3'd0);
    check("mr_fen", fsrc_en, 1'b0);
    check("mr_fstop", fsrc_stop, 1'b1);
    check("mr_setval", accum_set_val, 64'h0);
    check("mr_addval", accum_add_val, 64'h0);
    cfg_accum_set_val = 64'h22; cfg_accum_add_val = 64'h3;
    pulse_start();
    check("mr2_armed", stat_state, 3'd1);
    tick();
    check("mr2_setval", accum_set_val, 64'h22);
    check("mr2_addval", accum_add_val, 64'h3);
    tick(); tick();
    check("mr2_run", stat_state, 3'd4);
    check("mr2_dstart", fsrc_data_start, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/axi_fsrc_tx_sequencer.md
Name: axi_fsrc_tx_sequencer

Overview:
Control sequencer for the FSRC TX rate-converter datapath. It turns regmap-level commands (enable, start, stop, rate change) and an optional external trigger into the cycle-exact control strobes the datapath consumes: fsrc_en, accum_set, fsrc_data_start and fsrc_stop, plus the accumulator values. It sits between the FSRC TX regmap and the tx_fsrc core, in the converter clock domain.

Parameters:
ACCUM_WIDTH, 64, accumulator set/add value width
CNT_WIDTH, 16, width of start-delay and stop-drain counters

Ports:
clk  in  1  converter clock
resetn  in  1  synchronous active-low reset
cfg_enable  in  1  level; low forces IDLE
cfg_ext_trig_en  in  1  level; 1 = start waits for ext_trig rising edge
cfg_start  in  1  one-cycle start command
cfg_stop  in  1  one-cycle stop command
cfg_change_rate  in  1  one-cycle rate-change command
cfg_start_delay  in  CNT_WIDTH  cycles between LOAD and data start
cfg_stop_drain  in  CNT_WIDTH  cycles datapath keeps running after stop
cfg_accum_set_val  in  ACCUM_WIDTH  accumulator initial value
cfg_accum_add_val  in  ACCUM_WIDTH  accumulator increment
ext_trig  in  1  external trigger, already synchronous to clk
fsrc_en  out  1  datapath enable
fsrc_data_start  out  1  one-cycle data start strobe
fsrc_stop  out  1  datapath stop/hold
accum_set  out  1  one-cycle accumulator load strobe
accum_set_val  out  ACCUM_WIDTH  latched set value
accum_add_val  out  ACCUM_WIDTH  latched add value
stat_state  out  3  current state encoding
stat_running  out  1  1 in RUN

Behaviour:
- All outputs registered; reset values: fsrc_en=0, fsrc_data_start=0, fsrc_stop=1, accum_set=0, accum_set_val=0, accum_add_val=0, stat_state=0, stat_running=0, counter=0, ext_trig_d=0.
- Trigger edge: trig_rise = ext_trig & ~ext_trig_d; ext_trig high in the first cycle after reset counts as an edge.
- States/encoding: IDLE=0, ARMED=1, LOAD=2, DELAY=3, RUN=4, DRAIN=5.
- IDLE: fsrc_en=0, fsrc_stop=1. cfg_start & cfg_enable & ~cfg_stop -> ARMED.
- ARMED: if ~cfg_ext_trig_en -> LOAD next cycle; else stay until trig_rise -> LOAD.
- LOAD (exactly 1 cycle): accum_set=1, fsrc_en=1; accum_set_val <= cfg_accum_set_val and accum_add_val <= cfg_accum_add_val, both visible in this cycle. Counter <= cfg_start_delay. -> DELAY.
- DELAY: fsrc_en=1, fsrc_stop=1. Counter==0 -> RUN, else decrement. Delay N gives N+1 DELAY cycles.
- RUN: fsrc_en=1, fsrc_stop=0, stat_running=1. fsrc_data_start=1 only in the first RUN cycle. cfg_stop -> DRAIN, counter <= cfg_stop_drain.
- DRAIN: fsrc_en=1, fsrc_stop=0; counter==0 -> IDLE (fsrc_stop=1 from the first IDLE cycle), else decrement.
- Rate change: cfg_change_rate in RUN or DRAIN -> accum_add_val <= cfg_accum_add_val next cycle. No accum_set strobe. Ignored in IDLE, ARMED and DELAY. LOAD already samples the value.
- Abort: cfg_stop in ARMED, LOAD or DELAY -> IDLE next cycle; drain is skipped.
- cfg_enable=0 in any state -> IDLE next cycle. This has priority over all commands.
- cfg_start outside IDLE is ignored. cfg_start and cfg_stop together in IDLE: stop wins, state stays IDLE.
- resetn low mid-operation: all registers return to reset values on the next clk edge, whatever the state.
- Timing from a start pulse in cycle t, trigger disabled, delay D: ARMED t+1, LOAD t+2, DELAY t+3..t+3+D, RUN/data_start at t+4+D.

Test Plan:
- Reset: hold resetn=0 with stimulus toggling -> fsrc_stop=1, all other outputs 0, stat_state=0.
- Basic start: trigger disabled, start_delay=3, set_val=0x10, add_val=0x5, start at t -> accum_set high at t+2 with accum_set_val=0x10; fsrc_data_start single pulse at t+7; stat_state=4.
- Ext trigger: trigger enabled, start, no edge for 20 cycles -> stays ARMED (1); trigger rises at cycle k -> LOAD at k+1.
- Rate change and stop: in RUN, add_val=0x9 plus change_rate -> accum_add_val=0x9 next cycle, no accum_set. Then stop_drain=4 with stop -> 5 DRAIN cycles, then fsrc_stop=1 and fsrc_en=0.
- Abort and priority: stop during DELAY -> IDLE next cycle with no data_start. cfg_enable dropped in RUN -> IDLE next cycle. Start and stop together in IDLE -> stays IDLE.
- Reset mid-RUN: resetn=0 for one cycle -> reset values on the next edge; a later start sequences normally.
